// File: rtl/eater_pkg.sv
// ---------------------------------------------------------------------------
// eater_pkg
// Shared definitions for the Eater-style 8-bit teaching CPU core:
//   - OPCODE_W   : width of the opcode field at the top of every word
//   - opcode_e   : instruction opcodes (anything not listed executes as NOP)
//   - tstate_e   : the five microcode steps T0..T4 of every instruction
// No ports; imported by eater_ram and eater_core.
// ---------------------------------------------------------------------------
package eater_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

endpackage

// File: rtl/eater_ram.sv
// ---------------------------------------------------------------------------
// eater_ram
// Unified program/data memory of the core: 2**ADDR_W words of DATA_W bits.
// Synchronous write, combinational read. Contents are deliberately not
// reset so a program survives a core reset.
// Ports:
//   clk    in   clock
//   we     in   write enable (already muxed between STA and programming)
//   waddr  in   ADDR_W write address
//   wdata  in   DATA_W write data
//   raddr  in   ADDR_W read address
//   rdata  out  DATA_W read data (combinational)
// ---------------------------------------------------------------------------
module eater_ram
    import eater_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/eater_core.sv
// ---------------------------------------------------------------------------
// eater_core
// Multi-cycle accumulator CPU in the style of the Ben Eater breadboard
// computer. Every instruction takes five steps T0..T4: T0 latches PC into
// MAR, T1 fetches into IR and increments PC, T2..T4 execute.
// Optional feature macro: EATER_COND_JUMP_EN enables JC/JZ; without it they
// behave as NOP although carry/zero are still maintained.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (memory is not cleared)
//   prog_mode  in   1 = core held at T0, memory writable from outside
//   prog_we    in   programming write strobe (only honoured in prog_mode)
//   prog_addr  in   ADDR_W programming address
//   prog_data  in   DATA_W programming data
//   out_data   out  DATA_W output register (written by OUT)
//   out_valid  out  one-cycle pulse after out_data is updated
//   halted     out  core stopped on HLT
//   pc         out  ADDR_W program counter (debug)
// ---------------------------------------------------------------------------
module eater_core
    import eater_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

`ifdef EATER_COND_JUMP_EN
    localparam bit COND_JUMP = 1'b1;
`else
    localparam bit COND_JUMP = 1'b0;
`endif

    tstate_e           state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              prog_prev_q, prog_prev_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   operand;
    logic [DATA_W:0]     add_full;
    logic [DATA_W:0]     sub_full;

    assign opcode  = ir_q[DATA_W-1 -: OPCODE_W];
    assign operand = ir_q[ADDR_W-1:0];

    // Subtraction as A + ~B + 1 so the top bit is the "no borrow" carry.
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};

    // Memory is always read at MAR: the fetch address in T1, the operand
    // address (loaded at T2) in T3.
    eater_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mar_q),
        .rdata (ram_rdata)
    );

    // Next-state logic. Priority: programming mode, then the cycle right
    // after leaving programming mode (clears the architectural state), then
    // normal execution unless halted. Programming mode simply overrides the
    // current T-state, so an in-flight instruction loses its side effects.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        prog_prev_d = prog_mode;
        ram_we      = 1'b0;
        ram_waddr   = mar_q;
        ram_wdata   = a_q;

        if (prog_mode) begin
            state_d   = T0;
            halted_d  = 1'b0;
            ram_we    = prog_we;
            ram_waddr = prog_addr;
            ram_wdata = prog_data;
        end else if (prog_prev_q) begin
            state_d = T0;
            pc_d    = '0;
            a_d     = '0;
            b_d     = '0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
        end else if (!halted_q) begin
            case (state_q)
                T0: begin
                    mar_d   = pc_q;
                    state_d = T1;
                end
                T1: begin
                    ir_d    = ram_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = T2;
                end
                T2: begin
                    state_d = T3;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand;
                        OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
                        OP_JMP: pc_d = operand;
                        OP_JC: begin
                            if (COND_JUMP && carry_q) pc_d = operand;
                        end
                        OP_JZ: begin
                            if (COND_JUMP && zero_q) pc_d = operand;
                        end
                        OP_OUT: begin
                            out_data_d  = a_q;
                            out_valid_d = 1'b1;
                        end
                        OP_HLT: begin
                            halted_d = 1'b1;
                            state_d  = T2;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    state_d = T4;
                    case (opcode)
                        OP_LDA:         a_d    = ram_rdata;
                        OP_ADD, OP_SUB: b_d    = ram_rdata;
                        OP_STA:         ram_we = 1'b1;
                        default: ;
                    endcase
                end
                T4: begin
                    state_d = T0;
                    case (opcode)
                        OP_ADD: begin
                            {carry_d, a_d} = add_full;
                            zero_d         = (add_full[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            {carry_d, a_d} = sub_full;
                            zero_d         = (sub_full[DATA_W-1:0] == '0);
                        end
                        default: ;
                    endcase
                end
                default: state_d = T0;
            endcase
        end
    end

    // All core registers share the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= T0;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            prog_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            prog_prev_q <= prog_prev_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc        = pc_q;

endmodule

// File: doc/eater_core.md
EATER_CORE -- requirements
Module: eater_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data/instruction word width; legal only if DATA_W >= ADDR_W+4.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; memory depth 2**ADDR_W words.
REQ-003 SHALL have these ports, in order:
- clk  in  1  the one clock.
- rst_n  in  1  asynchronous, active-low reset.
- prog_mode  in  1  high = core held, memory writable.
- prog_we  in  1  memory write strobe, honoured only in prog_mode.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  DATA_W  write data.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- halted  out  1  core stopped on HLT.
- pc  out  ADDR_W  current program counter (debug).

Function
REQ-004 SHALL decode each instruction word as opcode = top 4 bits and operand = low ADDR_W bits.
REQ-005 SHALL implement these opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; every other opcode is NOP.
REQ-006 SHALL execute every instruction in exactly 5 cycles, with states T0..T4 and T4 returning to T0.
- T0: MAR<=PC.
- T1: IR<=mem[MAR], PC<=PC+1 (wraps mod 2**ADDR_W).
- T2..T4: execute.
REQ-007 SHALL give each opcode this effect:
- LDA: A<=mem[op].
- ADD: B<=mem[op], then A<=A+B.
- SUB: B<=mem[op], then A<=A-B.
- STA: mem[op]<=A.
- LDI: A<=zero-extended operand.
- JMP: PC<=op.
- OUT: out_data<=A, out_valid pulses for exactly the T2 edge's following cycle.
REQ-008 SHALL do ADD/SUB arithmetic modulo 2**DATA_W.
REQ-009 SHALL update carry on ADD as the carry-out and on SUB as carry-out of A+~B+1 (1 = no borrow).
REQ-010 SHALL set zero when the ADD/SUB result equals 0; no other instruction changes carry or zero.
REQ-011 SHALL, on HLT at T2, set halted=1 and freeze all state until reset or a prog_mode pulse.
REQ-012 SHALL, while prog_mode=1:
- hold state at T0 and keep out_valid=0 and halted=0;
- write mem[prog_addr]<=prog_data on each clk edge with prog_we=1.
REQ-013 SHALL treat prog_mode as taking priority over execution in any T-state, aborting the in-flight instruction without its side effects.
REQ-014 SHALL, on the cycle prog_mode is sampled low after being high:
- clear PC, A, B and flags to 0;
- begin T0 on the next cycle.
REQ-015 SHALL ignore prog_we when prog_mode=0.
REQ-016 SHALL let STA self-modify memory, with the new value visible to a later fetch.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force PC=0, A=0, B=0, carry=0, zero=0, out_data=0, out_valid=0, halted=0, state=T0.
REQ-018 SHALL leave memory contents unchanged by reset.
REQ-019 SHALL, on release with prog_mode=0, start fetching from address 0 on the first clk edge.

Configuration
REQ-020 SHALL, with EATER_COND_JUMP_EN defined, make JC load PC<=op when carry=1 and JZ load PC<=op when zero=1, and otherwise leave PC unchanged.
REQ-021 SHALL, without EATER_COND_JUMP_EN, execute JC and JZ as NOP, with carry and zero still computed.

Structure
REQ-022 SHALL place the opcode enum, the T-state enum (T0..T4) and the opcode width constant (4) in shared package eater_pkg.
REQ-023 SHALL place memory in sub-module eater_ram: 2**ADDR_W x DATA_W, synchronous write, combinational read, one write port shared by STA and programming via mux.

Verification
REQ-024 SHALL cover: program [LDA 14, ADD 15, OUT, HLT], mem14=28, mem15=14 -> out_data=42 with one out_valid pulse, then halted=1 after 20 cycles.
REQ-025 SHALL cover: LDI 3, SUB 15 with mem15=5 -> A=0xFE, carry=0; with mem15=3 -> A=0, zero=1, carry=1.
REQ-026 SHALL cover, with EATER_COND_JUMP_EN: counter loop [LDI 1, ADD 15, OUT, JC 5, JMP 1, HLT], mem15=0x40 -> out sequence 0x41, 0x81, 0xC1, 0x01, then halt.
REQ-027 SHALL cover, without EATER_COND_JUMP_EN: the same program never halts, and out_data cycles through 0x41, 0x81, 0xC1, 0x01, 0x41 (wrap).
REQ-028 SHALL cover: prog_mode asserted during T3 of an STA -> no memory write, PC=0, A=0 after release, fetch restarts at address 0.
REQ-029 SHALL cover: rst_n pulsed low mid-run -> all outputs 0 immediately, memory contents preserved and re-executed.
